// File: rtl/riscv_dmi_arbiter.sv
// Round-robin share of one DM DMI port between two requesters, one transaction outstanding; DM request at accept+1, response at DM rsp+1.
// Requesters hold valid until ready, DM response has no backpressure; `DMI_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles.
module riscv_dmi_arbiter #(
  parameter int ABITS   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic             tck_i,
  input  logic             trst_i,
  input  logic             m0_req_valid_i,
  output logic             m0_req_ready_o,
  input  logic [ABITS-1:0] m0_req_addr_i,
  input  logic [31:0]      m0_req_data_i,
  input  logic [1:0]       m0_req_op_i,
  output logic             m0_rsp_valid_o,
  output logic [31:0]      m0_rsp_data_o,
  output logic [1:0]       m0_rsp_op_o,
  output logic             m0_busy_o,
  output logic             m0_err_o,
  input  logic             m0_dmireset_i,
  input  logic             m1_req_valid_i,
  output logic             m1_req_ready_o,
  input  logic [ABITS-1:0] m1_req_addr_i,
  input  logic [31:0]      m1_req_data_i,
  input  logic [1:0]       m1_req_op_i,
  output logic             m1_rsp_valid_o,
  output logic [31:0]      m1_rsp_data_o,
  output logic [1:0]       m1_rsp_op_o,
  output logic             m1_busy_o,
  output logic             m1_err_o,
  input  logic             m1_dmireset_i,
  output logic             dm_req_valid_o,
  input  logic             dm_req_ready_i,
  output logic [ABITS-1:0] dm_req_addr_o,
  output logic [31:0]      dm_req_data_o,
  output logic [1:0]       dm_req_op_o,
  input  logic             dm_rsp_valid_i,
  input  logic [31:0]      dm_rsp_data_i,
  input  logic [1:0]       dm_rsp_op_i
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [ABITS-1:0] addr;
    logic [31:0]      data;
    logic [1:0]       op;
  } dmi_req_t;

  state_t     r_state, w_state_nxt;
  logic       r_owner, r_last;
  dmi_req_t   r_req, w_sel_req;
  logic [31:0] r_rsp_data, w_rsp_data;
  logic [1:0] r_rsp_op, w_rsp_op;
  logic       w_rsp_ld;
  logic [1:0] r_err;
  logic [1:0] w_gnt;
  logic       w_idle, w_accept, w_resp, w_rsp_fail, w_tmo_hit;

  // Contention goes to the port that did not win last time.
  assign w_gnt[0] = m0_req_valid_i & (~m1_req_valid_i | r_last);
  assign w_gnt[1] = m1_req_valid_i & (~m0_req_valid_i | ~r_last);
  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & (|w_gnt);
  assign m0_req_ready_o = w_idle & w_gnt[0];
  assign m1_req_ready_o = w_idle & w_gnt[1];

  always_comb begin
    if (w_gnt[1]) w_sel_req = '{addr: m1_req_addr_i, data: m1_req_data_i, op: m1_req_op_i};
    else          w_sel_req = '{addr: m0_req_addr_i, data: m0_req_data_i, op: m0_req_op_i};
  end

`ifdef DMI_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_tmo_cnt;

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i)                 r_tmo_cnt <= '0;
    else if (r_state == S_REQ)  r_tmo_cnt <= '0;
    else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo_hit = (r_tmo_cnt == CW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_tmo_hit        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_ld    = 1'b0;
    w_rsp_data  = dm_rsp_data_i;
    w_rsp_op    = dm_rsp_op_i;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_sel_req.op == 2'd1 || w_sel_req.op == 2'd2) begin
            w_state_nxt = S_REQ;
          end else begin
            // NOP and reserved op are answered locally, never forwarded to the DM.
            w_state_nxt = S_RESP;
            w_rsp_ld    = 1'b1;
            w_rsp_data  = '0;
            w_rsp_op    = (w_sel_req.op == 2'd0) ? 2'd0 : 2'd2;
          end
        end
      end
      S_REQ:  if (dm_req_ready_i) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (dm_rsp_valid_i) begin
          w_state_nxt = S_RESP;
          w_rsp_ld    = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_RESP;
          w_rsp_ld    = 1'b1;
          w_rsp_data  = '0;
          w_rsp_op    = 2'd2;
        end
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_req      <= '0;
      r_rsp_data <= '0;
      r_rsp_op   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner <= w_gnt[1];
        r_last  <= w_gnt[1];
        r_req   <= w_sel_req;
      end
      if (w_rsp_ld) begin
        r_rsp_data <= w_rsp_data;
        r_rsp_op   <= w_rsp_op;
      end
    end
  end

  assign w_resp     = (r_state == S_RESP);
  assign w_rsp_fail = w_resp & (r_rsp_op == 2'd2);

  // A failure reported in the same cycle as dmireset keeps the flag set.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      r_err <= '0;
    end else begin
      if (w_rsp_fail & ~r_owner)   r_err[0] <= 1'b1;
      else if (m0_dmireset_i)      r_err[0] <= 1'b0;
      if (w_rsp_fail & r_owner)    r_err[1] <= 1'b1;
      else if (m1_dmireset_i)      r_err[1] <= 1'b0;
    end
  end

  assign dm_req_valid_o = (r_state == S_REQ);
  assign dm_req_addr_o  = dm_req_valid_o ? r_req.addr : '0;
  assign dm_req_data_o  = dm_req_valid_o ? r_req.data : '0;
  assign dm_req_op_o    = dm_req_valid_o ? r_req.op   : '0;

  assign m0_rsp_valid_o = w_resp & ~r_owner;
  assign m1_rsp_valid_o = w_resp & r_owner;
  assign m0_rsp_data_o  = m0_rsp_valid_o ? r_rsp_data : '0;
  assign m1_rsp_data_o  = m1_rsp_valid_o ? r_rsp_data : '0;
  assign m0_rsp_op_o    = m0_rsp_valid_o ? r_rsp_op : '0;
  assign m1_rsp_op_o    = m1_rsp_valid_o ? r_rsp_op : '0;
  assign m0_busy_o      = ~w_idle & ~r_owner;
  assign m1_busy_o      = ~w_idle & r_owner;
  assign m0_err_o       = r_err[0];
  assign m1_err_o       = r_err[1];
endmodule
